key_loader_dbuf: RTL and testbench
==================================

// Module: key_loader_dbuf
// PURPOSE
//  Parametrised, double-buffered key loader for the XOR cipher datapath.
//  Collects KEY_W-bit keys from a stream of WORD_W-bit words over a valid/ready handshake into a shadow buffer.
//  Commits each completed key atomically to the active key register, but only while the encrypt core is not busy.
//  The next key can therefore be loaded while the current key is in use.
// PARAMETERS
//  WORD_W     32   width of one incoming key word
//  KEY_W      512  assembled key width; must be an integer multiple of WORD_W
//  MSB_FIRST  0    0: first word lands in bits [WORD_W-1:0]; 1: first word lands in the top slot
// PORTS
//  iClk         in   1       clock, rising edge
//  iRst         in   1       reset, asynchronous, active-low
//  iClear       in   1       synchronous clear: discard the partial key and invalidate the active key
//  iWord        in   WORD_W  key word
//  iWord_valid  in   1       iWord is valid this cycle
//  oWord_ready  out  1       loader accepts a word this cycle
//  iBusy        in   1       encrypt core is using oKey; blocks commit
//  oKey         out  KEY_W   active key
//  oKey_valid   out  1       oKey holds a committed key
//  oSwap        out  1       one-cycle pulse on the cycle after a commit edge
//  oWord_count  out  CW      words held in shadow buffer; CW=$clog2(NWORDS+1), NWORDS=KEY_W/WORD_W
// BEHAVIOUR
//  - Reset values (iRst low, immediate):
//      state=FILL, shadow=0, oKey=0, oKey_valid=0, oSwap=0, oWord_count=0, oWord_ready=1.
//  - oWord_ready = (state==FILL) && !iClear. Combinational, no dependence on iWord_valid.
//  - Accept on a rising edge with iWord_valid && oWord_ready:
//      * LSB-first: write shadow[cnt*WORD_W +: WORD_W].
//      * MSB_FIRST: write slot NWORDS-1-cnt.
//      * Then cnt <= cnt+1.
//  - Accepting the word at cnt==NWORDS-1 sets cnt=NWORDS and moves state to FULL. This is the edge t.
//  - FULL state:
//      * Accepts no words.
//      * On any edge where iBusy==0 is sampled (earliest t+1): oKey<=shadow, oKey_valid<=1, oSwap<=1 for one cycle, cnt<=0, state<=FILL.
//      * If iBusy stays high, remain in FULL indefinitely with oKey unchanged.
//  - In FILL, iBusy is ignored; filling proceeds while the core is busy.
//  - Each commit replaces all KEY_W bits in one edge; no partial key is ever visible on oKey.
//  - Once set, oKey_valid stays 1 across later commits until iClear or reset.
//  - iClear has priority over accept and commit:
//      * Next edge: shadow=0, cnt=0, state=FILL, oKey=0, oKey_valid=0, oSwap=0.
//      * A word presented in the same cycle as iClear is not accepted.
//  - Gaps in iWord_valid of any length are legal; no timeout.
//  - Reset asserted mid-fill or in FULL returns to the reset values immediately, and the partial or pending key is lost.
//  - A word may be accepted on the first edge after the commit edge; there is no extra turnaround.
//  - Throughput: sustained 1 word/cycle.
//      * Key period with iBusy low = NWORDS+1 cycles (NWORDS accepts + 1 commit).
// TESTING
//  1 LSB-first: 16 back-to-back words 0x00000000..0x0000000F, iBusy=0
//    -> oKey[i*32+:32]==i; oKey_valid=1 and oSwap pulse one edge after the 16th accept; ready low for exactly that 1 cycle.
//  2 MSB_FIRST=1: same stimulus -> oKey[511:480]==0, oKey[31:0]==0xF.
//  3 iBusy held high from before the 16th word for 5 cycles
//    -> oWord_ready=0, oWord_count=16, oKey stays at the old key; commit on the first edge with iBusy=0.
//  4 iClear after 7 words, with iWord_valid high in the same cycle
//    -> that word is dropped, count=0, oKey_valid=0; the next 16 words (0xA0..0xAF) form the key exactly.
//  5 Load key A, then key B while iBusy=1
//    -> oKey==A until iBusy falls; then oKey==B in one edge, oKey_valid never drops.
//  6 Async iRst pulse while in FULL -> all outputs at reset values without a clock edge; a fresh 16-word load works.

Source files
------------

// File: rtl/key_loader_dbuf.sv
// Double-buffered key loader: assembles a key from a word stream into a shadow
// buffer and swaps it into the active key register while the core is idle.
module key_loader_dbuf #(
    parameter int WORD_W    = 32,
    parameter int KEY_W     = 512,
    parameter bit MSB_FIRST = 1'b0,
    localparam int NWORDS   = KEY_W / WORD_W,
    localparam int CW       = $clog2(NWORDS + 1)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iClear,
    input  logic [WORD_W-1:0] iWord,
    input  logic              iWord_valid,
    output logic              oWord_ready,
    input  logic              iBusy,
    output logic [KEY_W-1:0]  oKey,
    output logic              oKey_valid,
    output logic              oSwap,
    output logic [CW-1:0]     oWord_count
);

    typedef enum logic {FILL, FULL} state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  shadow_q, shadow_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              kv_q, kv_d;
    logic              swap_q, swap_d;
    logic [CW-1:0]     slot;

    assign slot = MSB_FIRST ? (CW'(NWORDS - 1) - cnt_q) : cnt_q;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q  <= FILL;
            shadow_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            kv_q     <= 1'b0;
            swap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            kv_q     <= kv_d;
            swap_q   <= swap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        key_d    = key_q;
        cnt_d    = cnt_q;
        kv_d     = kv_q;
        swap_d   = 1'b0;
        // Clear wins over both accept and commit
        if (iClear) begin
            state_d  = FILL;
            shadow_d = '0;
            key_d    = '0;
            cnt_d    = '0;
            kv_d     = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (iWord_valid) begin
                        shadow_d[int'(slot)*WORD_W +: WORD_W] = iWord;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(NWORDS - 1)) state_d = FULL;
                    end
                end
                FULL: begin
                    if (!iBusy) begin
                        key_d   = shadow_q;
                        kv_d    = 1'b1;
                        swap_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    assign oWord_ready = (state_q == FILL) && !iClear;
    assign oKey        = key_q;
    assign oKey_valid  = kv_q;
    assign oSwap       = swap_q;
    assign oWord_count = cnt_q;

endmodule

// File: tb/tb_key_loader_dbuf.sv
// Directed bench for key_loader_dbuf: one LSB-first and one MSB-first
// instance share the same stimulus.
module tb_key_loader_dbuf;

    localparam int WW = 32;
    localparam int KW = 512;
    localparam int NW = KW / WW;
    localparam int CW = $clog2(NW + 1);

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iClear = 1'b0;
    logic [WW-1:0] iWord = '0;
    logic          iWord_valid = 1'b0;
    logic          iBusy = 1'b0;

    logic          rdy_l, kv_l, swp_l;
    logic [KW-1:0] key_l;
    logic [CW-1:0] cnt_l;
    logic          rdy_m, kv_m, swp_m;
    logic [KW-1:0] key_m;
    logic [CW-1:0] cnt_m;

    int errors = 0;
    int checks = 0;

    always #5 iClk = ~iClk;

    key_loader_dbuf #(.WORD_W(WW), .KEY_W(KW), .MSB_FIRST(1'b0)) u_lsb (
        .iClk(iClk), .iRst(iRst), .iClear(iClear), .iWord(iWord),
        .iWord_valid(iWord_valid), .oWord_ready(rdy_l), .iBusy(iBusy),
        .oKey(key_l), .oKey_valid(kv_l), .oSwap(swp_l), .oWord_count(cnt_l)
    );

    key_loader_dbuf #(.WORD_W(WW), .KEY_W(KW), .MSB_FIRST(1'b1)) u_msb (
        .iClk(iClk), .iRst(iRst), .iClear(iClear), .iWord(iWord),
        .iWord_valid(iWord_valid), .oWord_ready(rdy_m), .iBusy(iBusy),
        .oKey(key_m), .oKey_valid(kv_m), .oSwap(swp_m), .oWord_count(cnt_m)
    );

    typedef struct {
        logic          clr;
        logic          vld;
        logic [WW-1:0] word;
        logic          busy;
        logic          e_rdy;
        logic [CW-1:0] e_cnt;
        logic          e_kv;
        logic          e_swp;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [KW-1:0] act,
                       input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [KW-1:0] mk_key(input int base, input bit msb);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < NW; i++) begin
            if (msb) k[(NW-1-i)*WW +: WW] = WW'(base + i);
            else     k[i*WW +: WW]        = WW'(base + i);
        end
        return k;
    endfunction

    task automatic chk_post(input string nm, input int cnt, input logic kv,
                            input logic swp);
        chk({nm, ".cnt_l"}, KW'(cnt_l), KW'(cnt));
        chk({nm, ".cnt_m"}, KW'(cnt_m), KW'(cnt));
        chk({nm, ".kv"}, KW'({kv_l, kv_m}), KW'({kv, kv}));
        chk({nm, ".swap"}, KW'({swp_l, swp_m}), KW'({swp, swp}));
    endtask

    // Feeds NW words base..base+NW-1; the last one is offered with busy_last
    task automatic load_key(input string nm, input int base,
                            input logic busy_last);
        for (int i = 0; i < NW; i++) begin
            iWord       = WW'(base + i);
            iWord_valid = 1'b1;
            iBusy       = (i == NW - 1) ? busy_last : 1'b0;
            #1;
            chk({nm, ".rdy"}, KW'({rdy_l, rdy_m}), KW'(2'b11));
            cyc();
        end
        iWord_valid = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, CW'(1), 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 32'h99, 1'b0, 1'b1, CW'(1), 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, CW'(2), 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, CW'(0), 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, CW'(1), 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b0, 32'h55, 1'b0, 1'b0, CW'(0), 1'b0, 1'b0};

        #12;
        chk("rst.rdy", KW'({rdy_l, rdy_m}), KW'(2'b11));
        chk_post("rst", 0, 1'b0, 1'b0);
        chk("rst.key", key_l | key_m, '0);
        iRst = 1'b1;
        cyc();

        for (int v = 0; v < 6; v++) begin
            iClear      = vt[v].clr;
            iWord_valid = vt[v].vld;
            iWord       = vt[v].word;
            iBusy       = vt[v].busy;
            #1;
            chk($sformatf("vec%0d.rdy", v), KW'({rdy_l, rdy_m}),
                KW'({vt[v].e_rdy, vt[v].e_rdy}));
            cyc();
            chk_post($sformatf("vec%0d", v), int'(vt[v].e_cnt),
                     vt[v].e_kv, vt[v].e_swp);
        end
        iClear = 1'b0;
        iWord_valid = 1'b0;
        iBusy = 1'b0;

        load_key("t1", 0, 1'b0);
        chk_post("t1.full", NW, 1'b0, 1'b0);
        chk("t1.full.rdy", KW'({rdy_l, rdy_m}), '0);
        cyc();
        chk_post("t1.commit", 0, 1'b1, 1'b1);
        chk("t1.commit.rdy", KW'({rdy_l, rdy_m}), KW'(2'b11));
        chk("t1.key_lsb", key_l, mk_key(0, 1'b0));
        chk("t2.key_msb", key_m, mk_key(0, 1'b1));
        chk("t2.msb_top", KW'(key_m[KW-1 -: WW]), '0);
        chk("t2.msb_low", KW'(key_m[WW-1:0]), KW'(32'hF));
        cyc();
        chk_post("t1.after", 0, 1'b1, 1'b0);

        load_key("t3", 32'h100, 1'b1);
        iBusy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t3.hold%0d.rdy", c), KW'({rdy_l, rdy_m}), '0);
            chk_post($sformatf("t3.hold%0d", c), NW, 1'b1, 1'b0);
            chk($sformatf("t3.hold%0d.key", c), key_l, mk_key(0, 1'b0));
            cyc();
        end
        iBusy = 1'b0;
        cyc();
        chk_post("t5.swap", 0, 1'b1, 1'b1);
        chk("t5.key_lsb", key_l, mk_key(32'h100, 1'b0));
        chk("t5.key_msb", key_m, mk_key(32'h100, 1'b1));

        for (int i = 0; i < 7; i++) begin
            iWord = WW'(32'h50 + i);
            iWord_valid = 1'b1;
            cyc();
        end
        chk_post("t4.partial", 7, 1'b1, 1'b0);
        iClear = 1'b1;
        iWord = 32'hDEAD;
        #1;
        chk("t4.clr.rdy", KW'({rdy_l, rdy_m}), '0);
        cyc();
        iClear = 1'b0;
        iWord_valid = 1'b0;
        chk_post("t4.clr", 0, 1'b0, 1'b0);
        chk("t4.clr.key", key_l | key_m, '0);
        cyc();
        chk_post("t4.idle", 0, 1'b0, 1'b0);
        load_key("t4", 32'hA0, 1'b0);
        cyc();
        chk_post("t4.commit", 0, 1'b1, 1'b1);
        chk("t4.key_lsb", key_l, mk_key(32'hA0, 1'b0));
        chk("t4.key_msb", key_m, mk_key(32'hA0, 1'b1));

        load_key("t6", 32'h300, 1'b1);
        iBusy = 1'b1;
        chk_post("t6.full", NW, 1'b1, 1'b0);
        #1;
        iRst = 1'b0;
        #1;
        chk("t6.rst.rdy", KW'({rdy_l, rdy_m}), KW'(2'b11));
        chk_post("t6.rst", 0, 1'b0, 1'b0);
        chk("t6.rst.key", key_l | key_m, '0);
        #1;
        iRst = 1'b1;
        iBusy = 1'b0;
        cyc();
        load_key("t6b", 32'h200, 1'b0);
        cyc();
        chk_post("t6.commit", 0, 1'b1, 1'b1);
        chk("t6.key_lsb", key_l, mk_key(32'h200, 1'b0));
        chk("t6.key_msb", key_m, mk_key(32'h200, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
